// File: rtl/riscv_mem_pkg.sv
// Shared types and widths for the data-memory responder and its RAM.
package riscv_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = $clog2(16);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: byte-lane synchronous writes, asynchronous read that the
// responder registers into its response.
module mem_array
  import riscv_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [STRB_W-1:0] we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave for the core's data port: one outstanding request, LATENCY
// wait states, byte-strobed word access and a registered response with error flag.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       LATENCY     = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned LIM_W = ADDR_W + 1;
  // One past the last valid byte, kept one bit wider so a top-of-space window cannot wrap.
  localparam logic [LIM_W-1:0] ADDR_LIMIT =
    {1'b0, BASE_ADDR} + LIM_W'(DEPTH_WORDS * WORD_BYTES);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  mem_req_t          live_req;
  mem_req_t          acc_req;
  logic [ADDR_W-1:0] acc_off;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic              do_acc;
  logic [STRB_W-1:0] mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Zero-latency accesses use the live request; otherwise the captured one.
  always_comb begin
    live_req.we    = req_we;
    live_req.addr  = req_addr;
    live_req.wdata = req_wdata;
    live_req.wstrb = req_wstrb;
    acc_req        = (state_q == MEM_IDLE) ? live_req : req_q;
    acc_off        = acc_req.addr - BASE_ADDR;
    acc_idx        = IDX_W'(acc_off >> 2);
    acc_err        = (acc_req.addr[1:0] != 2'b00) |
                     (acc_req.addr < BASE_ADDR) |
                     ({1'b0, acc_req.addr} >= ADDR_LIMIT);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    do_acc      = 1'b0;
    mem_we      = '0;

    case (state_q)
      MEM_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_d       = live_req;
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            do_acc      = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = MEM_RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY);
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          do_acc      = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = MEM_RESP;
        end
      end
      MEM_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = MEM_IDLE;
        end
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase

    if (do_acc) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_req.we | acc_err) ? '0 : mem_rdata;
      // Reset wins over an access landing on the same edge.
      if (acc_req.we && !acc_err && !reset) begin
        mem_we = acc_req.wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .addr    (acc_idx),
    .wdata   (acc_req.wdata),
    .rdata_c (mem_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 0 with a non-zero base, 1 and 15)
// checked against directed vectors and a word-array reference model.
module tb_dmem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  function automatic int unsigned lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0000_1000 : 32'h0;
  endfunction

  logic                  clk;
  logic [NDUT-1:0]       reset;
  logic [NDUT-1:0]       req_valid;
  logic [NDUT-1:0]       req_we;
  logic [NDUT-1:0][31:0] req_addr;
  logic [NDUT-1:0][31:0] req_wdata;
  logic [NDUT-1:0][3:0]  req_wstrb;
  logic [NDUT-1:0]       rsp_ready;
  wire  [NDUT-1:0]       req_ready;
  wire  [NDUT-1:0]       rsp_valid;
  wire  [NDUT-1:0][31:0] rsp_rdata;
  wire  [NDUT-1:0]       rsp_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (lat_of(g)),
      .BASE_ADDR   (base_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [NDUT][DEPTH];

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed window of DEPTH words above the base, word granularity.
  function automatic void model_access(input int k, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] wstrb,
                                       output logic [31:0] rd, output logic err);
    longint unsigned a, b, lim, idx;
    a   = longint'(addr);
    b   = longint'(base_of(k));
    lim = b + DEPTH * 4;
    err = (a % 4 != 0) || (a < b) || (a >= lim);
    rd  = '0;
    if (!err) begin
      idx = (a - b) / 4;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) ref_mem[k][idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = ref_mem[k][idx];
      end
    end
  endfunction

  // One handshake; starts and ends just after a falling edge.
  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int m;
    logic bad, stable, er0;
    logic [31:0] rd0;
    chk($sformatf("%s ready_idle", nm), 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    rsp_ready[k] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_wstrb[k] = 4'($urandom);
    m = 0;
    bad = 1'b0;
    while (rsp_valid[k] !== 1'b1 && m < 40) begin
      if (req_ready[k] !== 1'b0) bad = 1'b1;
      @(negedge clk);
      m++;
    end
    chk($sformatf("%s latency", nm), 32'(m + 1), 32'(lat_of(k) + 1));
    chk($sformatf("%s busy_ready", nm), 32'(bad), 32'd0);
    chk($sformatf("%s rdata", nm), rsp_rdata[k], exp_rd);
    chk($sformatf("%s err", nm), 32'(rsp_err[k]), 32'(exp_err));
    rd0 = rsp_rdata[k];
    er0 = rsp_err[k];
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd0 || rsp_err[k] !== er0 ||
          req_ready[k] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk($sformatf("%s hold_stable", nm), 32'(stable), 32'd1);
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk($sformatf("%s after_valid_ready", nm), 32'({rsp_valid[k], req_ready[k]}), 32'b01);
  endtask

  // Store accepted, then reset lands on edge accept+wait_n+1; committed only if access edge passed.
  task automatic rst_mid(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                         input int wait_n, input string nm);
    logic seen;
    logic [31:0] rd;
    logic er;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = 4'hF;
    rsp_ready[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    repeat (wait_n) @(negedge clk);
    reset[k] = 1'b1;
    @(negedge clk);
    reset[k] = 1'b0;
    if (wait_n >= int'(lat_of(k))) model_access(k, 1'b1, addr, wdata, 4'hF, rd, er);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid[k] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk($sformatf("%s no_rsp", nm), 32'(seen), 32'd0);
    chk($sformatf("%s ready", nm), 32'(req_ready[k]), 32'd1);
    chk($sformatf("%s rdata_clr", nm), rsp_rdata[k], 32'd0);
  endtask

  task automatic rand_txn(input int i);
    int k, sel;
    logic [31:0] b, a, wd, rd;
    logic [3:0] ws;
    logic we, er;
    k   = $urandom_range(0, NDUT - 1);
    b   = base_of(k);
    sel = $urandom_range(0, 9);
    if (sel <= 6)      a = b + 32'($urandom_range(0, 15) * 4);
    else if (sel == 7) a = b + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else if (sel == 8) a = b + 32'h400 + 32'($urandom_range(0, 255) * 4);
    else if (k == 0)   a = b - 32'($urandom_range(1, 64) * 4);
    else               a = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
    we = 1'($urandom_range(0, 1));
    wd = $urandom;
    ws = 4'($urandom_range(0, 15));
    model_access(k, we, a, wd, ws, rd, er);
    txn(k, we, a, wd, ws, $urandom_range(0, 3), rd, er, $sformatf("rnd%0d_k%0d", i, k));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    reset     = '1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = '0;

    // Directed vectors; addresses below 0x1000 target k=1 (base 0), k=0 has base 0x1000.
    tbl.push_back('{1, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1, 1'b1, 32'h20,  32'h11223344, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b0, 32'h20,  32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1, 1'b0, 32'h22,  32'h0,        4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1});
    tbl.push_back('{1, 1'b0, 32'h0,   32'h0,        4'h0, 0, 32'hA5A50000, 1'b0});
    tbl.push_back('{1, 1'b0, 32'h20,  32'h0,        4'h0, 5, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1, 1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b0, 32'h24,  32'h0,        4'h0, 0, 32'hA5A50009, 1'b0});
    tbl.push_back('{1, 1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1, 1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b0, 32'h3FC, 32'h0,        4'h0, 2, 32'h0BADCAFE, 1'b0});
    tbl.push_back('{1, 1'b1, 32'h22,  32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1});
    tbl.push_back('{1, 1'b0, 32'h20,  32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0});
    tbl.push_back('{0, 1'b1, 32'h1010, 32'h55AA55AA, 4'hF, 0, 32'h0,       1'b0});
    tbl.push_back('{0, 1'b0, 32'h1010, 32'h0,       4'h0, 0, 32'h55AA55AA, 1'b0});
    tbl.push_back('{0, 1'b0, 32'hFFC,  32'h0,       4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 32'h1400, 32'h0,       4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 32'h13FC, 32'h01020304, 4'hF, 0, 32'h0,       1'b0});
    tbl.push_back('{0, 1'b0, 32'h13FC, 32'h0,       4'h0, 3, 32'h01020304, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h1000, 32'h0,       4'h0, 0, 32'hA5A50000, 1'b0});
    tbl.push_back('{2, 1'b1, 32'h30,  32'h12345678, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{2, 1'b0, 32'h30,  32'h0,        4'h0, 3, 32'h12345678, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = '0;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_k%0d req_ready", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("rst_k%0d rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("rst_k%0d rsp_rdata", k), rsp_rdata[k], 32'd0);
      chk($sformatf("rst_k%0d rsp_err", k), 32'(rsp_err[k]), 32'd0);
    end

    // Known contents for the first 16 words of every build.
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 16; w++) begin
        model_access(k, 1'b1, base_of(k) + 32'(w * 4), 32'hA5A5_0000 | 32'(w), 4'hF, rd, er);
        txn(k, 1'b1, base_of(k) + 32'(w * 4), 32'hA5A5_0000 | 32'(w), 4'hF, 0, 32'h0, 1'b0,
            $sformatf("init_k%0d_w%0d", k, w));
      end
    end

    for (int i = 0; i < tbl.size(); i++) begin
      model_access(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, er);
      txn(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].hold,
          tbl[i].exp_rd, tbl[i].exp_err, $sformatf("tbl%0d", i));
    end

    // Reset in WAIT, on the access edge (both drop the store), and in RESP (store kept).
    rst_mid(2, 32'h30, 32'hCAFEF00D, 3, "rst_wait");
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, "rst_wait_reload");
    rst_mid(2, 32'h30, 32'hCAFEF00D, 14, "rst_accedge");
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, "rst_accedge_reload");
    rst_mid(2, 32'h34, 32'h600DF00D, 20, "rst_resp");
    txn(2, 1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h600DF00D, 1'b0, "rst_resp_reload");

    for (int i = 0; i < 300; i++) rand_txn(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
